exchange_judge: RTL and testbench

Replica-exchange decision stage for one adjacent replica pair (k, k+1). It sits directly upstream of the two per-replica exchange buffers. At the end of an annealing round it applies the parallel-tempering Metropolis test to the pair's tour distances and issues one `exchange_command_t` to each replica. It then tracks the city_div-word route transfer until completion.

---
 rtl/exchange_judge_pkg.sv | 29 ++
 rtl/exchange_judge_nlog_rom.sv | 19 +
 rtl/exchange_judge.sv | 121 ++++++++++++
 tb/tb_exchange_judge.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/exchange_judge_pkg.sv
// Shared widths, types and state encoding for the replica-exchange decision stage.
package exchange_judge_pkg;

  localparam int unsigned dist_bit     = 16;
  localparam int unsigned beta_bit     = 16;
  localparam int unsigned city_div     = 4;
  localparam int unsigned city_div_log = 2;
  localparam int unsigned nlog_bit     = 12;

  typedef logic [dist_bit-1:0]          distance_t;
  typedef logic [beta_bit-1:0]          beta_t;
  typedef logic [dist_bit+beta_bit-1:0] product_t;

  typedef enum logic [1:0] {
    NOP  = 2'd0,
    PREV = 2'd1,
    FOLW = 2'd2,
    SELF = 2'd3
  } exchange_command_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_JUDGE,
    ST_ISSUE,
    ST_XFER
  } judge_state_t;

endpackage

// File: rtl/exchange_judge_nlog_rom.sv
// 256-entry table of -ln((i+0.5)/256)*256, rounded; indexed by the LFSR low byte.
module nlog_rom
  import exchange_judge_pkg::*;
(
  input  logic [7:0]          index,
  output logic [nlog_bit-1:0] value
);

  logic [nlog_bit-1:0] rom [256];

  // Entries are elaborated constants, so this reduces to a plain lookup table.
  for (genvar i = 0; i < 256; i++) begin : g_rom
    localparam int ENTRY = int'(-$ln((real'(i) + 0.5) / 256.0) * 256.0);
    assign rom[i] = nlog_bit'(ENTRY);
  end

  assign value = rom[index];

endmodule

// File: rtl/exchange_judge.sv
// Parallel-tempering Metropolis judgement for one replica pair, then route-transfer tracking.
module exchange_judge
  import exchange_judge_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [dist_bit-1:0] distance_lo,
  input  logic [dist_bit-1:0] distance_hi,
  input  logic [beta_bit-1:0] delta_beta,
  input  logic                xfer_valid,
  output exchange_command_t   command_lo,
  output exchange_command_t   command_hi,
  output logic                busy,
  output logic                done,
  output logic                swapped
);

  judge_state_t        state, state_d;
  exchange_command_t   command_lo_d, command_hi_d;
  logic                busy_d, done_d, swapped_d;

  distance_t           dist_lo_q, dist_hi_q;
  beta_t               beta_q;
  logic [15:0]         lfsr;
  product_t            prod_q;
  logic                worse_q;
  logic [nlog_bit-1:0] nlog_q, nlog_val;
  logic [city_div_log-1:0] count;

  logic      accept, last_word, worse, swap, feedback;
  distance_t diff;

  // The done cycle is already IDLE, so a start there must be masked explicitly.
  assign accept    = (state == ST_IDLE) && start && !done;
  assign last_word = (state == ST_XFER) && xfer_valid &&
                     (count == city_div_log'(city_div - 1));
  assign diff      = dist_lo_q - dist_hi_q;
  assign worse     = dist_hi_q > dist_lo_q;
  assign swap      = worse_q | (prod_q <= product_t'(nlog_q));
  assign feedback  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  nlog_rom u_nlog_rom (
    .index (lfsr[7:0]),
    .value (nlog_val)
  );

  always_comb begin
    state_d      = state;
    command_lo_d = command_lo;
    command_hi_d = command_hi;
    swapped_d    = swapped;
    case (state)
      ST_IDLE:  if (accept) state_d = ST_CALC;
      ST_CALC:  state_d = ST_JUDGE;
      ST_JUDGE: begin
        state_d      = ST_ISSUE;
        command_lo_d = swap ? FOLW : SELF;
        command_hi_d = swap ? PREV : SELF;
        swapped_d    = swap;
      end
      ST_ISSUE: begin
        state_d      = ST_XFER;
        command_lo_d = NOP;
        command_hi_d = NOP;
      end
      ST_XFER:  if (last_word) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = last_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      command_lo <= NOP;
      command_hi <= NOP;
      busy       <= 1'b0;
      done       <= 1'b0;
      swapped    <= 1'b0;
    end else begin
      state      <= state_d;
      command_lo <= command_lo_d;
      command_hi <= command_hi_d;
      busy       <= busy_d;
      done       <= done_d;
      swapped    <= swapped_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dist_lo_q <= '0;
      dist_hi_q <= '0;
      beta_q    <= '0;
      lfsr      <= SEED;
      prod_q    <= '0;
      worse_q   <= 1'b0;
      nlog_q    <= '0;
      count     <= '0;
    end else begin
      if (accept) begin
        dist_lo_q <= distance_lo;
        dist_hi_q <= distance_hi;
        beta_q    <= delta_beta;
        lfsr      <= {lfsr[14:0], feedback};
      end
      if (state == ST_CALC) begin
        worse_q <= worse;
        prod_q  <= worse ? '0 : product_t'(diff) * product_t'(beta_q);
        nlog_q  <= nlog_val;
      end
      if ((state == ST_XFER) && xfer_valid)
        count <= last_word ? '0 : count + 1'b1;
    end
  end

endmodule

// File: tb/tb_exchange_judge.sv
// Directed vector table plus hand sequences for transfer timing, masking and mid-transfer reset.
module tb_exchange_judge;
  import exchange_judge_pkg::*;

  logic              clk = 1'b0;
  logic              reset, start, xfer_valid;
  logic [15:0]       distance_lo, distance_hi, delta_beta;
  exchange_command_t command_lo, command_hi;
  logic              busy, done, swapped;

  int unsigned nchk  = 0;
  int unsigned nfail = 0;

  exchange_judge #(.SEED(16'hACE1)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .distance_lo (distance_lo),
    .distance_hi (distance_hi),
    .delta_beta  (delta_beta),
    .xfer_valid  (xfer_valid),
    .command_lo  (command_lo),
    .command_hi  (command_hi),
    .busy        (busy),
    .done        (done),
    .swapped     (swapped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]       dlo;
    logic [15:0]       dhi;
    logic [15:0]       beta;
    exchange_command_t exp_lo;
    exchange_command_t exp_hi;
    logic              exp_sw;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic judge(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    distance_lo = a;
    distance_hi = b;
    delta_beta  = c;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  task automatic run_vec(input int unsigned idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    judge(v.dlo, v.dhi, v.beta);
    chk({tag, " busy_c1"}, busy, 1'b1);
    chk({tag, " lo_c1"}, command_lo, NOP);
    tick();
    chk({tag, " lo_c2"}, command_lo, NOP);
    tick();
    chk({tag, " lo_issue"}, command_lo, v.exp_lo);
    chk({tag, " hi_issue"}, command_hi, v.exp_hi);
    chk({tag, " swapped"}, swapped, v.exp_sw);
    tick();
    chk({tag, " lo_xfer"}, command_lo, NOP);
    chk({tag, " hi_xfer"}, command_hi, NOP);
    chk({tag, " swapped_held"}, swapped, v.exp_sw);
    for (int w = 0; w < 4; w++) begin
      xfer_valid = 1'b1;
      tick();
      if (w < 3) chk({tag, " done_early"}, done, 1'b0);
    end
    xfer_valid = 1'b0;
    chk({tag, " done"}, done, 1'b1);
    chk({tag, " busy_at_done"}, busy, 1'b0);
    tick();
    chk({tag, " done_pulse"}, done, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{16'd100,   16'd200,   16'h0100, FOLW, PREV, 1'b1};
    vecs[1] = '{16'd1000,  16'd0,     16'h0100, SELF, SELF, 1'b0};
    vecs[2] = '{16'd500,   16'd500,   16'h0100, FOLW, PREV, 1'b1};
    vecs[3] = '{16'd900,   16'd100,   16'h0000, FOLW, PREV, 1'b1};
    vecs[4] = '{16'd2,     16'd1,     16'h0700, SELF, SELF, 1'b0};
    vecs[5] = '{16'd65535, 16'd0,     16'hFFFF, SELF, SELF, 1'b0};
    vecs[6] = '{16'd2,     16'd1,     16'h0001, FOLW, PREV, 1'b1};
    vecs[7] = '{16'd0,     16'd65535, 16'hFFFF, FOLW, PREV, 1'b1};
    vecs[8] = '{16'd3,     16'd1,     16'h0340, SELF, SELF, 1'b0};

    reset = 1'b1; start = 1'b0; xfer_valid = 1'b0;
    distance_lo = '0; distance_hi = '0; delta_beta = '0;
    repeat (2) tick();
    chk("rst lo", command_lo, NOP);
    chk("rst hi", command_hi, NOP);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst swapped", swapped, 1'b0);
    reset = 1'b0;
    tick();

    for (int unsigned i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // sparse xfer_valid, start mid-transfer and on the done cycle are ignored
    judge(16'd100, 16'd200, 16'h0100);
    repeat (3) tick();
    tick();
    xfer_valid = 1'b1; tick();
    xfer_valid = 1'b0; start = 1'b1;
    chk("seq done_c6", done, 1'b0);
    tick();
    start = 1'b0; xfer_valid = 1'b1; tick();
    tick();
    xfer_valid = 1'b0;
    chk("seq done_c9", done, 1'b0);
    tick();
    chk("seq done_c10", done, 1'b0);
    xfer_valid = 1'b1; tick();
    xfer_valid = 1'b0;
    chk("seq done_c11", done, 1'b1);
    chk("seq busy_c11", busy, 1'b0);
    chk("seq swapped_c11", swapped, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("seq done_c12", done, 1'b0);
    chk("seq busy_c12", busy, 1'b0);
    tick();
    chk("seq busy_c13", busy, 1'b0);

    // xfer_valid held high from before start: only XFER cycles count
    xfer_valid = 1'b1;
    judge(16'd2, 16'd1, 16'h0001);
    for (int c = 1; c < 8; c++) begin
      chk($sformatf("early_valid done_c%0d", c), done, 1'b0);
      tick();
    end
    xfer_valid = 1'b0;
    chk("early_valid done_c8", done, 1'b1);
    tick();

    // reset in XFER after two words abandons the transfer
    judge(16'd500, 16'd500, 16'h0100);
    repeat (3) tick();
    xfer_valid = 1'b1; tick();
    tick();
    xfer_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("midrst busy", busy, 1'b0);
    chk("midrst lo", command_lo, NOP);
    chk("midrst hi", command_hi, NOP);
    chk("midrst swapped", swapped, 1'b0);
    chk("midrst done", done, 1'b0);
    tick();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("postrst done", done, 1'b0);
      chk("postrst busy", busy, 1'b0);
    end
    judge(16'd1000, 16'd0, 16'h0100);
    repeat (3) tick();
    for (int w = 0; w < 3; w++) begin
      xfer_valid = 1'b1; tick();
      chk("restart done_early", done, 1'b0);
    end
    xfer_valid = 1'b1; tick();
    xfer_valid = 1'b0;
    chk("restart done", done, 1'b1);
    chk("restart swapped", swapped, 1'b0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
    $finish;
  end

endmodule
